// File: rtl/fringe_pkg.sv
// Shared types and constant helpers for the structured-light fringe sequencer.
// Holds the sequencer state encoding and the rounded DDS phase-step calculation.
package fringe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } fringe_state_t;

    // round(2^pw / n_steps), done in 64-bit so pw = 32 does not overflow
    function automatic logic [63:0] phase_step(input int unsigned pw, input int unsigned n_steps);
        logic [63:0] full_turn;
        full_turn = 64'd1 << pw;
        return (full_turn + 64'(n_steps / 2)) / 64'(n_steps);
    endfunction

endpackage

// File: rtl/fringe_recip_div.sv
// Restoring divider producing one quotient bit per clock; computes the DDS
// phase increment 2^PW/d. A start while busy aborts the current divide.
module fringe_recip_div #(
    parameter int PW = 32
) (
    input  logic          clk_25,
    input  logic          reset,
    input  logic          start,
    input  logic [PW:0]   num,
    input  logic [PW-1:0] den,
    output logic [PW-1:0] quo,
    output logic          done
);

    localparam int CW = $clog2(PW + 2);

    logic [PW:0]   num_reg;
    logic [PW-1:0] rem_reg;
    logic [PW-1:0] q_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;

    logic [PW:0]   trial;
    logic [PW-1:0] diff;
    logic          ge;

    always_comb begin
        trial = {rem_reg, num_reg[PW]};
        ge    = (trial >= {1'b0, den});
        // when ge holds the true difference is below den, so the low PW bits are exact
        diff  = trial[PW-1:0] - den;
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            num_reg  <= '0;
            rem_reg  <= '0;
            q_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            num_reg  <= num;
            rem_reg  <= '0;
            q_reg    <= '0;
            cnt_reg  <= CW'(PW + 1);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            if (cnt_reg != '0) begin
                num_reg <= {num_reg[PW-1:0], 1'b0};
                rem_reg <= ge ? diff : trial[PW-1:0];
                q_reg   <= {q_reg[PW-2:0], ge};
                cnt_reg <= cnt_reg - 1'b1;
            end else begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done = busy_reg & (cnt_reg == '0);
    assign quo  = q_reg;

endmodule

// File: rtl/fringe_sequencer.sv
// Phase-shift / multi-frequency fringe sequencer driving the row-clocked DDS.
// Define FRINGE_LOOP_EN to wrap back to K=1 after the last frame instead of stopping in DONE.
module fringe_sequencer
    import fringe_pkg::*;
#(
    parameter int PW            = 32,
    parameter int N_STEPS       = 4,
    parameter int N_FREQS       = 120,
    parameter int PERIOD_BASE   = 4,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic          clk_25,
    input  logic          reset,
    input  logic          vsync,
    input  logic          cam_trig,
    input  logic          cam_ready,
    output logic [PW-1:0] phase_inc,
    output logic [PW-1:0] phase_off,
    output logic          inc_valid,
    output logic [7:0]    step_idx,
    output logic [7:0]    freq_k,
    output logic          cam_sync,
    output logic          seq_done
);

    localparam logic [63:0] PHASE_STEP = phase_step(PW, N_STEPS);
    localparam int          SW         = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

    logic [1:0]    sync_meta_reg;
    logic [1:0]    sync_reg;
    logic          trig_sync;
    logic          ready_sync;
    logic          vsync_prev_reg;
    logic          frame_evt;

    fringe_state_t state_reg, state_next;
    logic [7:0]    step_reg, step_next;
    logic [7:0]    freq_reg, freq_next;
    logic [SW-1:0] settle_reg, settle_next;

    logic [PW-1:0] phase_off_reg;
    logic [PW-1:0] phase_inc_reg;
    logic          inc_valid_reg;
    logic          init_reg;

    logic          div_start;
    logic [PW-1:0] div_den;
    logic [PW:0]   div_num;
    logic [PW-1:0] div_quo;
    logic          div_done;

    // camera handshake lines are asynchronous: two-flop synchronisers
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            sync_meta_reg  <= 2'b00;
            sync_reg       <= 2'b00;
            vsync_prev_reg <= 1'b0;
        end else begin
            sync_meta_reg  <= {cam_ready, cam_trig};
            sync_reg       <= sync_meta_reg;
            vsync_prev_reg <= vsync;
        end
    end

    assign trig_sync  = sync_reg[0];
    assign ready_sync = sync_reg[1];
    assign frame_evt  = vsync_prev_reg & ~vsync;

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            step_reg   <= 8'd0;
            freq_reg   <= 8'd1;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            freq_reg   <= freq_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        freq_next   = freq_reg;
        settle_next = settle_reg;
        if (!trig_sync) begin
            // losing the trigger abandons the sequence from any state
            state_next  = ST_IDLE;
            step_next   = 8'd0;
            freq_next   = 8'd1;
            settle_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_ARMED;
                ST_ARMED: begin
                    if (ready_sync) begin
                        state_next  = ST_SETTLE;
                        settle_next = '0;
                    end
                end
                ST_SETTLE: begin
                    if (frame_evt) begin
                        if (settle_reg == SW'(SETTLE_FRAMES - 1)) begin
                            state_next = ST_RUN;
                        end else begin
                            settle_next = settle_reg + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!ready_sync) begin
                        // counters hold so the interrupted pattern is re-projected, not skipped
                        state_next  = ST_SETTLE;
                        settle_next = '0;
                    end else if (frame_evt) begin
                        if (step_reg == 8'(N_STEPS - 1)) begin
                            if (freq_reg == 8'(N_FREQS)) begin
`ifdef FRINGE_LOOP_EN
                                step_next = 8'd0;
                                freq_next = 8'd1;
`else
                                state_next = ST_DONE;
`endif
                            end else begin
                                step_next = 8'd0;
                                freq_next = freq_reg + 8'd1;
                            end
                        end else begin
                            step_next = step_reg + 8'd1;
                        end
                    end
                end
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            phase_off_reg <= '0;
        end else begin
            phase_off_reg <= PW'(64'(step_reg) * PHASE_STEP);
        end
    end

    // divider loads the new K on the same edge freq_k changes, and once after reset
    assign div_start = init_reg | (freq_next != freq_reg);
    assign div_den   = PW'(PERIOD_BASE) * PW'(freq_next);
    assign div_num   = {1'b1, {PW{1'b0}}} + {1'b0, div_den >> 1};

    fringe_recip_div #(
        .PW (PW)
    ) u_div (
        .clk_25 (clk_25),
        .reset  (reset),
        .start  (div_start),
        .num    (div_num),
        .den    (div_den),
        .quo    (div_quo),
        .done   (div_done)
    );

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            init_reg      <= 1'b1;
            inc_valid_reg <= 1'b0;
            phase_inc_reg <= '0;
        end else begin
            init_reg <= 1'b0;
            if (div_start) begin
                inc_valid_reg <= 1'b0;
            end else if (div_done) begin
                inc_valid_reg <= 1'b1;
                phase_inc_reg <= div_quo;
            end
        end
    end

    assign phase_inc = phase_inc_reg;
    assign phase_off = phase_off_reg;
    assign inc_valid = inc_valid_reg;
    assign step_idx  = step_reg;
    assign freq_k    = freq_reg;
    assign cam_sync  = vsync & (state_reg == ST_RUN);
    assign seq_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_fringe_sequencer.sv
// Self-checking bench for fringe_sequencer: random frame timing and random cam_ready
// drops, checked against a frame-level model of the sequence (honours FRINGE_LOOP_EN).
module tb_fringe_sequencer;

    localparam int PW            = 32;
    localparam int N_STEPS       = 4;
    localparam int N_FREQS       = 120;
    localparam int PERIOD_BASE   = 4;
    localparam int SETTLE_FRAMES = 2;
`ifdef FRINGE_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk_25 = 1'b0;
    logic          reset;
    logic          vsync;
    logic          cam_trig;
    logic          cam_ready;
    logic [PW-1:0] phase_inc;
    logic [PW-1:0] phase_off;
    logic          inc_valid;
    logic [7:0]    step_idx;
    logic [7:0]    freq_k;
    logic          cam_sync;
    logic          seq_done;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    typedef enum int {M_IDLE, M_ARMED, M_SETTLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode;
    int    m_step;
    int    m_k;
    int    m_settle;
    bit    m_trig;
    bit    m_ready;

    fringe_sequencer #(
        .PW            (PW),
        .N_STEPS       (N_STEPS),
        .N_FREQS       (N_FREQS),
        .PERIOD_BASE   (PERIOD_BASE),
        .SETTLE_FRAMES (SETTLE_FRAMES)
    ) dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .vsync     (vsync),
        .cam_trig  (cam_trig),
        .cam_ready (cam_ready),
        .phase_inc (phase_inc),
        .phase_off (phase_off),
        .inc_valid (inc_valid),
        .step_idx  (step_idx),
        .freq_k    (freq_k),
        .cam_sync  (cam_sync),
        .seq_done  (seq_done)
    );

    always #20 clk_25 = ~clk_25;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (model K=%0d step=%0d): observed %0d expected %0d", tag, m_k, m_step, obs, exp);
        end
    endtask

    // nearest-integer 2^PW / (PERIOD_BASE*K)
    function automatic longint exp_inc(input int k);
        longint d;
        d = longint'(PERIOD_BASE) * k;
        return ((longint'(1) << PW) + d / 2) / d;
    endfunction

    function automatic longint exp_off(input int s);
        longint st;
        st = ((longint'(1) << PW) + N_STEPS / 2) / N_STEPS;
        return (s * st) % (longint'(1) << PW);
    endfunction

    // level-sensitive rules of the handshake, applied once the inputs have settled
    task automatic apply_levels();
        if (!m_trig) begin
            m_mode = M_IDLE; m_step = 0; m_k = 1; m_settle = 0;
        end else begin
            if (m_mode == M_IDLE) m_mode = M_ARMED;
            if (m_mode == M_ARMED && m_ready) begin m_mode = M_SETTLE; m_settle = 0; end
            if (m_mode == M_RUN && !m_ready) begin m_mode = M_SETTLE; m_settle = 0; end
        end
    endtask

    // one frame: the sequence is a flat index over K-major, step-minor patterns
    task automatic model_frame();
        int flat;
        case (m_mode)
            M_SETTLE: begin
                m_settle++;
                if (m_settle == SETTLE_FRAMES) m_mode = M_RUN;
            end
            M_RUN: begin
                flat = (m_k - 1) * N_STEPS + m_step + 1;
                if (flat == N_STEPS * N_FREQS) begin
                    if (LOOP) begin m_step = 0; m_k = 1; end
                    else m_mode = M_DONE;
                end else begin
                    m_step = flat % N_STEPS;
                    m_k    = flat / N_STEPS + 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic set_levels(input bit trig, input bit ready);
        @(negedge clk_25);
        cam_trig = trig; cam_ready = ready;
        m_trig = trig; m_ready = ready;
        repeat (6) @(negedge clk_25);
        apply_levels();
    endtask

    task automatic check_reset_state();
        check("rst_phase_inc", phase_inc, 0);
        check("rst_phase_off", phase_off, 0);
        check("rst_inc_valid", inc_valid, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_freq_k", freq_k, 1);
        check("rst_cam_sync", cam_sync, 0);
        check("rst_seq_done", seq_done, 0);
    endtask

    task automatic check_idle();
        check("idle_step_idx", step_idx, 0);
        check("idle_freq_k", freq_k, 1);
        check("idle_seq_done", seq_done, 0);
        check("idle_cam_sync", cam_sync, 0);
    endtask

    task automatic check_outputs();
        check("cam_sync_low", cam_sync, 0);
        check("seq_done", seq_done, (m_mode == M_DONE));
        if (m_mode != M_DONE) begin
            check("step_idx", step_idx, m_step);
            check("freq_k", freq_k, m_k);
            check("phase_off", phase_off, exp_off(m_step));
            check("phase_inc", phase_inc, exp_inc(m_k));
        end
        check("inc_valid", inc_valid, 1);
    endtask

    task automatic run_frame();
        int prev_k;
        int low;
        int lat;
        int w;
        @(negedge clk_25);
        vsync = 1'b1;
        repeat (5) @(negedge clk_25);
        check("cam_sync_high", cam_sync, (m_mode == M_RUN));
        @(negedge clk_25);
        vsync = 1'b0;
        prev_k = m_k;
        model_frame();
        low = $urandom_range(40, 56);
        lat = 0;
        w = 0;
        if (m_k != prev_k) begin
            @(negedge clk_25);
            w = 1;
            while (freq_k === 8'(prev_k) && w < 5) begin @(negedge clk_25); w++; end
            check("freq_k_change", freq_k, m_k);
            check("inc_valid_drop", inc_valid, 0);
            while (inc_valid !== 1'b1 && lat < 60) begin @(negedge clk_25); lat++; end
            check("inc_valid_latency", lat, 34);
        end
        repeat ((low > lat + w + 2) ? (low - lat - w) : 2) @(negedge clk_25);
        check_outputs();
        frame_no++;
        $display("frame %0d: mode=%s K=%0d step=%0d phase_inc=%0d phase_off=%0d",
                 frame_no, m_mode.name(), freq_k, step_idx, phase_inc, phase_off);
    endtask

    initial begin
        int n;
        bit wrapped;
        reset = 1'b1; vsync = 1'b0; cam_trig = 1'b0; cam_ready = 1'b0;
        m_trig = 1'b0; m_ready = 1'b0;
        m_mode = M_IDLE; m_step = 0; m_k = 1; m_settle = 0;
        repeat (3) @(negedge clk_25);
        check_reset_state();
        reset = 1'b0;

        // divider starts on leaving reset
        repeat (40) @(negedge clk_25);
        check("boot_inc_valid", inc_valid, 1);
        check("boot_phase_inc_k1", phase_inc, exp_inc(1));

        set_levels(1'b1, 1'b0);
        run_frame();
        set_levels(1'b1, 1'b1);

        n = 0;
        while (!(m_mode == M_RUN && m_k == 7 && m_step == 2) && n < 200) begin
            run_frame();
            n++;
        end
        check("reach_k7_budget", (n < 200), 1);

        // re-settle at K=7 step 2 must neither skip nor repeat a pattern
        set_levels(1'b1, 1'b0);
        check("hold_step_idx", step_idx, 2);
        check("hold_freq_k", freq_k, 7);
        set_levels(1'b1, 1'b1);
        repeat (3) run_frame();
        check("resume_step_idx", step_idx, 3);
        check("resume_freq_k", freq_k, 7);

        n = 0;
        wrapped = 1'b0;
        while (m_mode != M_DONE && !wrapped && n < 700) begin
            if (m_mode == M_RUN && $urandom_range(0, 23) == 0) begin
                set_levels(1'b1, 1'b0);
                set_levels(1'b1, 1'b1);
            end
            run_frame();
            n++;
            if (LOOP && m_mode == M_RUN && m_k == 1 && m_step == 0) wrapped = 1'b1;
        end
        check("sequence_end_budget", (n < 700), 1);
        if (LOOP) begin
            check("loop_step_idx", step_idx, 0);
            check("loop_freq_k", freq_k, 1);
            check("loop_seq_done", seq_done, 0);
        end else begin
            check("done_seq_done", seq_done, 1);
        end
        repeat (2) run_frame();

        // trigger loss returns to IDLE from wherever the sequence is
        set_levels(1'b0, 1'b1);
        check_idle();
        run_frame();
        set_levels(1'b1, 1'b1);
        repeat (6) run_frame();
        set_levels(1'b0, 1'b1);
        check_idle();
        set_levels(1'b1, 1'b1);
        repeat (5) run_frame();

        // hand-driven frame so that reset lands while the divider is busy on K=2
        @(negedge clk_25);
        vsync = 1'b1;
        repeat (6) @(negedge clk_25);
        vsync = 1'b0;
        model_frame();
        repeat (10) @(negedge clk_25);
        check("pre_reset_freq_k", freq_k, m_k);
        check("mid_divide_inc_valid", inc_valid, 0);
        reset = 1'b1;
        #1;
        check_reset_state();
        m_mode = M_IDLE; m_step = 0; m_k = 1; m_settle = 0;
        repeat (2) @(negedge clk_25);
        check_reset_state();
        reset = 1'b0;
        repeat (40) @(negedge clk_25);
        apply_levels();
        check("post_reset_inc_valid", inc_valid, 1);
        check("post_reset_phase_inc", phase_inc, exp_inc(1));
        repeat (3) run_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
